// File: rtl/chess_input_ctrl_pkg.sv
// Shared definitions for the chess timer input controller: FSM encoding,
// button indices, registered control bundle and debounce defaults.
package chess_pkg;

   typedef enum logic [2:0] {
      SETUP  = 3'd0,
      READY  = 3'd1,
      RUN_P1 = 3'd2,
      RUN_P2 = 3'd3,
      PAUSED = 3'd4,
      FLAG   = 3'd5
   } state_e;

   localparam int DEBOUNCE_CYCLES_DEF = 1000000;
   localparam int CNT_W_DEF           = 20;

   localparam int NUM_BTN   = 5;
   localparam int BTN_P1    = 0;
   localparam int BTN_P2    = 1;
   localparam int BTN_SET   = 2;
   localparam int BTN_MIN   = 3;
   localparam int BTN_PAUSE = 4;

   typedef struct packed {
      logic enable;
      logic sw0;
      logic sw1;
      logic set;
   } ctrl_t;

   // Moore decode; PAUSED and FLAG keep showing the side that was running.
   function automatic ctrl_t decode(state_e st, logic last_p2);
      ctrl_t c;
      c = '0;
      case (st)
         READY:  ;
         RUN_P1: begin c.enable = 1'b1; c.sw0 = 1'b1; end
         RUN_P2: begin c.enable = 1'b1; c.sw1 = 1'b1; end
         PAUSED, FLAG: begin c.sw0 = ~last_p2; c.sw1 = last_p2; end
         default: c.set = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/chess_input_ctrl_if.sv
// Button/flag inputs and control outputs between the user panel side and
// the input controller.
interface chess_input_if;
   logic btn_p1;
   logic btn_p2;
   logic btn_set;
   logic btn_min;
   logic btn_pause;
   logic time_up;
   logic enable;
   logic sw0;
   logic sw1;
   logic set;
   logic min;

   modport master (
      output btn_p1, btn_p2, btn_set, btn_min, btn_pause, time_up,
      input  enable, sw0, sw1, set, min
   );

   modport slave (
      input  btn_p1, btn_p2, btn_set, btn_min, btn_pause, time_up,
      output enable, sw0, sw1, set, min
   );
endinterface

// File: rtl/chess_input_ctrl_debounce.sv
// One button: 2-FF synchroniser, stability counter, registered press pulse
// on the accepted 0->1 transition.
module debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic level_o,
   output logic press_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d, stable_dly_q;
   logic             press_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any cycle where the synced input agrees with the stable level restarts the count.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_MAX) stable_d = ~stable_q;
         else                  cnt_d    = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         stable_q     <= 1'b0;
         stable_dly_q <= 1'b0;
         press_q      <= 1'b0;
         cnt_q        <= '0;
      end else begin
         sync1_q      <= btn_i;
         sync2_q      <= sync1_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         press_q      <= stable_q & ~stable_dly_q;
         cnt_q        <= cnt_d;
      end
   end

   assign level_o = stable_q;
   assign press_o = press_q;

endmodule

// File: rtl/chess_input_ctrl.sv
// Chess timer front end: debounces the five buttons and runs the game-flow
// FSM driving enable/sw0/sw1/set/min to the counter block.
module chess_input_ctrl
   import chess_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF
) (
   input logic           clk,
   input logic           reset,
   chess_input_if.slave  bus
);

   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] press;
   logic [NUM_BTN-1:0] level_unused;

   assign btn_raw = {bus.btn_pause, bus.btn_min, bus.btn_set, bus.btn_p2, bus.btn_p1};

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
      debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_db (
         .clk    (clk),
         .reset  (reset),
         .btn_i  (btn_raw[i]),
         .level_o(level_unused[i]),
         .press_o(press[i])
      );
   end

   state_e state_q, state_d;
   logic   last_p2_q, last_p2_d;
   ctrl_t  ctrl_q, ctrl_d;
   logic   min_q, min_d;

   always_comb begin
      state_d   = state_q;
      last_p2_d = last_p2_q;
      case (state_q)
         SETUP:  if (press[BTN_SET]) state_d = READY;
         // Pressing your own button hands the move to the opponent.
         READY: begin
            if (press[BTN_P1] && !press[BTN_P2])      state_d = RUN_P2;
            else if (press[BTN_P2] && !press[BTN_P1]) state_d = RUN_P1;
         end
         RUN_P1: begin
            if (bus.time_up)           state_d = FLAG;
            else if (press[BTN_PAUSE]) state_d = PAUSED;
            else if (press[BTN_P1])    state_d = RUN_P2;
         end
         RUN_P2: begin
            if (bus.time_up)           state_d = FLAG;
            else if (press[BTN_PAUSE]) state_d = PAUSED;
            else if (press[BTN_P2])    state_d = RUN_P1;
         end
         PAUSED: begin
            if (bus.time_up)           state_d = FLAG;
            else if (press[BTN_SET])   state_d = SETUP;
            else if (press[BTN_PAUSE]) state_d = last_p2_q ? RUN_P2 : RUN_P1;
         end
         FLAG:   if (press[BTN_SET]) state_d = SETUP;
         default: state_d = SETUP;
      endcase
      if (state_d == RUN_P1)      last_p2_d = 1'b0;
      else if (state_d == RUN_P2) last_p2_d = 1'b1;
      ctrl_d = decode(state_d, last_p2_d);
      min_d  = (state_q == SETUP) && press[BTN_MIN];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= SETUP;
         last_p2_q <= 1'b0;
         ctrl_q    <= '{enable: 1'b0, sw0: 1'b0, sw1: 1'b0, set: 1'b1};
         min_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_p2_q <= last_p2_d;
         ctrl_q    <= ctrl_d;
         min_q     <= min_d;
      end
   end

   assign bus.enable = ctrl_q.enable;
   assign bus.sw0    = ctrl_q.sw0;
   assign bus.sw1    = ctrl_q.sw1;
   assign bus.set    = ctrl_q.set;
   assign bus.min    = min_q;

endmodule

// File: tb/tb_chess_input_ctrl.sv
// Directed bench for chess_input_ctrl with a short debounce window.
module tb_chess_input_ctrl;

   localparam int D = 4;
   localparam logic [4:0] P1 = 5'b00001, P2 = 5'b00010, SET = 5'b00100,
                          MIN = 5'b01000, PAUSE = 5'b10000, NONE = 5'b00000;
   // expected outputs packed as {enable, sw0, sw1, set}
   localparam logic [3:0] O_SETUP = 4'b0001, O_IDLE = 4'b0000, O_R1 = 4'b1100,
                          O_R2 = 4'b1010, O_H1 = 4'b0100, O_H2 = 4'b0010;

   typedef struct {
      logic [4:0] mask;
      logic       tu;
      logic [3:0] exp;
      int         nmin;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0, errors = 0, min_cnt = 0, both_cnt = 0;
   vec_t vecs[26];

   always #5 clk = ~clk;

   chess_input_if bus ();

   chess_input_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   task automatic drive(input logic [4:0] m);
      {bus.btn_pause, bus.btn_min, bus.btn_set, bus.btn_p2, bus.btn_p1} = m;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (bus.min) min_cnt++;
      if (bus.sw0 && bus.sw1) both_cnt++;
   endtask

   task automatic chk_out(input string nm, input logic [3:0] exp);
      logic [3:0] act;
      act = {bus.enable, bus.sw0, bus.sw1, bus.set};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: en/sw0/sw1/set got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_bit(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   // Press, hold until the FSM has reacted, release and let the release settle.
   task automatic press(input logic [4:0] m, input logic tu);
      drive(m);
      bus.time_up = tu;
      repeat (9) step();
      drive(NONE);
      repeat (10) step();
      bus.time_up = 1'b0;
      step();
   endtask

   task automatic hold_min(input string nm);
      drive(MIN);
      for (int k = 1; k <= 14; k++) begin
         step();
         chk_bit($sformatf("%s_%0d", nm, k), bus.min, k == 9);
         if (k == 10) drive(NONE);
      end
      repeat (12) step();
   endtask

   initial begin
      vecs[0]  = '{MIN,     1'b0, O_SETUP, 1};
      vecs[1]  = '{SET,     1'b0, O_IDLE,  0};
      vecs[2]  = '{P1 | P2, 1'b0, O_IDLE,  0};
      vecs[3]  = '{NONE,    1'b1, O_IDLE,  0};
      vecs[4]  = '{P1,      1'b0, O_R2,    0};
      vecs[5]  = '{P1,      1'b0, O_R2,    0};
      vecs[6]  = '{MIN,     1'b0, O_R2,    0};
      vecs[7]  = '{SET,     1'b0, O_R2,    0};
      vecs[8]  = '{P2,      1'b0, O_R1,    0};
      vecs[9]  = '{P2,      1'b0, O_R1,    0};
      vecs[10] = '{PAUSE,   1'b0, O_H1,    0};
      vecs[11] = '{P1,      1'b0, O_H1,    0};
      vecs[12] = '{PAUSE,   1'b0, O_R1,    0};
      vecs[13] = '{P1,      1'b0, O_R2,    0};
      vecs[14] = '{PAUSE,   1'b0, O_H2,    0};
      vecs[15] = '{P2,      1'b0, O_H2,    0};
      vecs[16] = '{PAUSE,   1'b0, O_R2,    0};
      vecs[17] = '{PAUSE,   1'b0, O_H2,    0};
      vecs[18] = '{NONE,    1'b1, O_H2,    0};
      vecs[19] = '{PAUSE,   1'b0, O_H2,    0};
      vecs[20] = '{P2,      1'b0, O_H2,    0};
      vecs[21] = '{MIN,     1'b0, O_H2,    0};
      vecs[22] = '{SET,     1'b0, O_SETUP, 0};
      vecs[23] = '{NONE,    1'b1, O_SETUP, 0};
      vecs[24] = '{SET,     1'b0, O_IDLE,  0};
      vecs[25] = '{P2,      1'b0, O_R1,    0};

      reset = 1'b1;
      drive(NONE);
      bus.time_up = 1'b0;
      repeat (3) step();
      chk_out("reset_state", O_SETUP);
      chk_bit("reset_min", bus.min, 1'b0);
      reset = 1'b0;

      min_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         chk_out($sformatf("idle_%0d", k), O_SETUP);
      end
      chk_int("idle_min_count", min_cnt, 0);

      hold_min("min_hold");

      min_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         bus.btn_min = ~bus.btn_min;
         step();
         step();
      end
      chk_int("bounce_no_pulse", min_cnt, 0);
      hold_min("bounce_hold");

      foreach (vecs[i]) begin
         min_cnt = 0;
         press(vecs[i].mask, vecs[i].tu);
         chk_out($sformatf("vec%0d", i), vecs[i].exp);
         chk_int($sformatf("vec%0d_min", i), min_cnt, vecs[i].nmin);
      end

      // time_up coincides with the p1 press pulse while P1 is running
      drive(P1);
      repeat (8) step();
      chk_out("flag_pre", O_R1);
      bus.time_up = 1'b1;
      step();
      chk_out("flag_entry", O_H1);
      bus.time_up = 1'b0;
      drive(NONE);
      repeat (10) step();
      chk_out("flag_hold", O_H1);
      press(PAUSE, 1'b0);
      chk_out("flag_pause", O_H1);
      press(P2, 1'b0);
      chk_out("flag_p2", O_H1);
      press(SET, 1'b0);
      chk_out("flag_set", O_SETUP);

      // reset lands mid-debounce of a held set button while P1 runs
      press(SET, 1'b0);
      press(P2, 1'b0);
      chk_out("pre_reset_run", O_R1);
      drive(SET);
      repeat (4) step();
      reset = 1'b1;
      step();
      chk_out("mid_reset", O_SETUP);
      chk_bit("mid_reset_min", bus.min, 1'b0);
      reset = 1'b0;
      repeat (8) step();
      chk_out("held_pre_press", O_SETUP);
      step();
      chk_out("held_press", O_IDLE);
      drive(NONE);
      repeat (10) step();
      chk_out("held_settle", O_IDLE);

      chk_int("sw_exclusive", both_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
